// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: op codes, FSM states,
// lane widths and the alignment rule applied when a request is accepted.
package mem_access_pkg;

    localparam logic [2:0] OP_LW = 3'b000;
    localparam logic [2:0] OP_LH = 3'b001;
    localparam logic [2:0] OP_LB = 3'b010;
    localparam logic [2:0] OP_SW = 3'b100;
    localparam logic [2:0] OP_SH = 3'b101;
    localparam logic [2:0] OP_SB = 3'b110;

    localparam int READ_WAIT_DEFAULT = 3;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WRITE,
        DONE,
        ERR
    } state_t;

    // op[1:0] is the access size (00 word, 01 half, 10 byte); 11 is undefined.
    function automatic logic access_illegal(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (op[1:0])
            2'b00:   bad = (off != 2'b00);
            2'b01:   bad = off[0];
            2'b10:   bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane logic: extracts the zero-extended load value from a
// memory word and merges sub-word store data into it.
module mem_lane_unit
    import mem_access_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        byte_off,
    input  logic [2:0]        op,
    output logic [WORD_W-1:0] load_val,
    output logic [WORD_W-1:0] store_word
);

    always_comb begin
        load_val = word;
        case (op)
            OP_LH:   load_val = {{(WORD_W-HALF_W){1'b0}}, word[HALF_W*byte_off[1] +: HALF_W]};
            OP_LB:   load_val = {{(WORD_W-BYTE_W){1'b0}}, word[BYTE_W*byte_off +: BYTE_W]};
            default: load_val = word;
        endcase
    end

    always_comb begin
        store_word = word;
        case (op)
            OP_SW:   store_word = wdata;
            OP_SH:   store_word[HALF_W*byte_off[1] +: HALF_W] = wdata[HALF_W-1:0];
            OP_SB:   store_word[BYTE_W*byte_off +: BYTE_W] = wdata[BYTE_W-1:0];
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer: fixed read wait, sub-word extraction and
// read-modify-write for SH/SB, with a one-cycle done/access_err completion.
//
// state   | meaning
// IDLE    | waiting for start; latches op/addr/wdata on accept
// RD_WAIT | mem_addr held for READ_WAIT cycles, word captured on the last
// WRITE   | mem_wr strobe for one cycle with the final store word
// DONE    | done pulse, load result presented
// ERR     | done + access_err pulse, no memory cycle
module mem_access_seq
    import mem_access_pkg::*;
#(
    parameter int READ_WAIT = READ_WAIT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        access_err
);

    localparam logic [2:0] WAIT_LOAD = 3'(READ_WAIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] wdata_hold;
    logic [31:0] rdata_q;
    logic [2:0]  wait_cnt;
    logic [31:0] load_val;
    logic [31:0] store_word;
    logic        is_load_q;

    mem_lane_unit u_lane (
        .word       (word_q),
        .wdata      (wdata_q),
        .byte_off   (addr_q[1:0]),
        .op         (op_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    assign is_load_q = ~op_q[2];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (access_illegal(op, addr[1:0])) state_nxt = ERR;
                    else if (op == OP_SW)               state_nxt = WRITE;
                    else                                state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (wait_cnt == 3'd0) state_nxt = is_load_q ? DONE : WRITE;
            end
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            wdata_hold <= '0;
            rdata_q    <= '0;
            wait_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                op_q     <= op;
                addr_q   <= addr;
                wdata_q  <= wdata;
                wait_cnt <= WAIT_LOAD;
            end
            if (state == RD_WAIT) begin
                if (wait_cnt == 3'd0) word_q <= mem_rdata;
                else                  wait_cnt <= wait_cnt - 3'd1;
            end
            if (state == WRITE) wdata_hold <= store_word;
            if (state == DONE && is_load_q) rdata_q <= load_val;
        end
    end

    // Results are muxed live in their own cycle and held in registers afterwards.
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wr     = (state == WRITE);
    assign mem_wdata  = mem_wr ? store_word : wdata_hold;
    assign busy       = (state == RD_WAIT) || (state == WRITE);
    assign done       = (state == DONE) || (state == ERR);
    assign access_err = (state == ERR);
    assign rdata      = (state == DONE && is_load_q) ? load_val : rdata_q;

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Multicycle load/store sequencer between the main control unit and the word-wide data memory. When the control unit issues a single `start` pulse, this block runs the memory's fixed read wait, extracts the byte or halfword for the load, and performs read-modify-write for sub-word stores. It then returns `done` with the result. It replaces per-instruction memory counters in the control FSM.

## Interface
- `READ_WAIT`, 3: cycles `mem_addr` is held with `mem_wr`=0 before `mem_rdata` is sampled; legal range 1..7.
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, sync reset active-high (fixed).
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  3  access type: LW 000, LH 001, LB 010, SW 100, SH 101, SB 110; 011/111 illegal.
- `addr`  in  32  byte address (ALUOut).
- `wdata`  in  32  store data (B register); low bits used for SH/SB.
- `mem_rdata`  in  32  memory read word.
- `mem_addr`  out  32  word address `{addr_q[31:2],2'b00}`.
- `mem_wdata`  out  32  word to write.
- `mem_wr`  out  1  memory write strobe (ReadWrite); 1 for exactly one cycle per store.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load result, zero-extended; held until next accepted `start`.
- `access_err`  out  1  pulses with `done` on misalignment or illegal op.

## Operation
- Reset values: every output 0, state IDLE, internal registers 0.
- IDLE: `start`=1 latches `op`, `addr`, `wdata` into `op_q`, `addr_q`, `wdata_q`.
  - `start` while busy is ignored, not queued.
- Checks at accept:
  - Illegal op → ERR.
  - LW/SW with `addr[1:0]`≠0 → ERR.
  - LH/SH with `addr[0]`=1 → ERR.
- Legal LW/LH/LB/SH/SB → RD_WAIT; legal SW → WRITE.
- RD_WAIT: hold `mem_addr`, `mem_wr`=0, wait counter 1..READ_WAIT. On the last cycle, capture `mem_rdata` into `word_q`.
  - Loads → DONE.
  - SH/SB → WRITE.
- Lanes are little-endian: byte k = bits [8k+7:8k], k=`addr_q[1:0]`; halfword h = bits [16h+15:16h], h=`addr_q[1]`.
- Loads:
  - LW: `rdata`=`word_q`.
  - LH: `rdata`={16'b0, halfword h}.
  - LB: `rdata`={24'b0, byte k}.
- WRITE: `mem_wr`=1 for one cycle, then → DONE.
  - SW: `mem_wdata`=`wdata_q`.
  - SH: `word_q` with halfword h replaced by `wdata_q[15:0]`.
  - SB: `word_q` with byte k replaced by `wdata_q[7:0]`.
- DONE: `done`=1, `busy`=0, → IDLE.
- ERR: `done`=1, `access_err`=1, no memory cycle, `rdata` unchanged, → IDLE.
- `mem_wdata` holds its last value outside WRITE; `mem_addr` holds `addr_q` in all states.
- A new `start` in the DONE cycle is ignored; the earliest accept is the cycle after `done`.

## Timing
- Cycle T = accepting edge.
- Latency from T to `done`:
  - Loads: READ_WAIT+1 (4 at default); `rdata` valid from the `done` cycle.
  - SW: `mem_wr` at T+1, `done` at T+2.
  - SH/SB: read T+1..T+READ_WAIT, `mem_wr` at T+READ_WAIT+1, `done` at T+READ_WAIT+2 (T+5 at default).
  - ERR: `done` and `access_err` at T+1.
- `busy` is high T+1 through the cycle before `done`, and low in the `done` cycle.
- Reset mid-operation: on the reset edge go to IDLE, force `mem_wr`=0, do not raise `done`, and clear `rdata`. A write already strobed stays committed; a pending RMW write is never issued.
- Reset has priority over `start` in the same cycle.

## Structure
- Package `mem_access_pkg`:
  - op encodings (LW..SB);
  - state enum (IDLE, RD_WAIT, WRITE, DONE, ERR);
  - `READ_WAIT_DEFAULT`;
  - helper constants for lane width.
- One combinational sub-module `mem_lane_unit`:
  - inputs `word`, `wdata`, `byte_off[1:0]`, `op`;
  - outputs the extracted load value and the merged store word.
- FSM, wait counter and latched registers live in `mem_access_seq`.

## Test plan
- Memory word at 0x100 = 0xA1B2C3D4; LW addr 0x100 → `done` at T+4, `rdata`=0xA1B2C3D4, `mem_wr` never 1.
- Same word; LB addr 0x101 → `rdata`=0x000000C3; LH addr 0x102 → `rdata`=0x0000A1B2.
- Same word; SB addr 0x103, wdata 0x000000EE → single `mem_wr` at T+4 with `mem_wdata`=0xEEB2C3D4, `done` T+5. Repeat with SH addr 0x100, wdata 0x1234 → 0xA1B21234.
- SW addr 0x104, wdata 0xDEADBEEF → `mem_wr`=1 at T+1 only, `mem_addr`=0x104, `done` T+2.
- LW addr 0x102 → `done`+`access_err` at T+1, no `mem_wr`, `rdata` unchanged; op=011 → same. A `start` pulse during a busy LW is ignored, giving exactly one `done`.
- `reset` asserted at T+2 of SB → next cycle all outputs 0, no `mem_wr`, no `done`. A fresh LW afterwards completes normally.
